// File: rtl/text_console_buffer.sv
// text_console_buffer
//   Character-cell terminal store of COLS x ROWS cells kept as a ring of rows.
//   Scrolling moves a top-row pointer. Line and screen clears are done by a
//   hardware sweep, one cell per cycle, so rows are never copied in bulk.
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   wr_valid/wr_ready   byte-stream writer handshake (ready only when idle)
//   wr_char             printable (0x20..0x7E) or control code (LF CR BS FF)
//   rd_col/rd_row       logical cell requested by the display path
//   rd_char             registered cell contents, valid one cycle after address
//   cursor_col/row      current write position (logical row)
//   busy                line or screen clear in progress
//   scroll_cnt          scrolls since reset / form feed, wraps at 2^16
module text_console_buffer #(
    parameter int COLS   = 70,
    parameter int ROWS   = 30,
    parameter int CHAR_W = 8,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS),
    localparam int AW = $clog2(COLS*ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [CHAR_W-1:0] wr_char,
    input  logic [CW-1:0]     rd_col,
    input  logic [RW-1:0]     rd_row,
    output logic [CHAR_W-1:0] rd_char,
    output logic [CW-1:0]     cursor_col,
    output logic [RW-1:0]     cursor_row,
    output logic              busy,
    output logic [15:0]       scroll_cnt
);
    typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     clr_idx, clr_idx_nxt;
    logic [AW-1:0]     clr_base, clr_base_nxt;
    logic [RW-1:0]     top, top_nxt;
    logic [CW-1:0]     col_nxt;
    logic [RW-1:0]     row_nxt;
    logic [15:0]       scroll_nxt;
    logic              do_nl;
    logic              wr_fire;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [CHAR_W-1:0] wdata;
    logic              rd_in_range;
    logic [AW-1:0]     raddr;

    logic [CHAR_W-1:0] mem [COLS*ROWS];

    // Logical (col,row) to flat cell index. top+row < 2*ROWS, so one
    // conditional subtract replaces the modulo.
    function automatic logic [AW-1:0] cell_addr(input logic [CW-1:0] c,
                                                 input logic [RW-1:0] r,
                                                 input logic [RW-1:0] t);
        logic [RW:0] p;
        p = {1'b0, t} + {1'b0, r};
        if (p >= (RW+1)'(ROWS))
            p = p - (RW+1)'(ROWS);
        return AW'(p) * AW'(COLS) + AW'(c);
    endfunction

    assign wr_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign wr_fire  = wr_valid && wr_ready;

    always_comb begin
        state_nxt    = state;
        clr_idx_nxt  = clr_idx;
        clr_base_nxt = clr_base;
        top_nxt      = top;
        col_nxt      = cursor_col;
        row_nxt      = cursor_row;
        scroll_nxt   = scroll_cnt;
        do_nl        = 1'b0;
        we           = 1'b0;
        waddr        = cell_addr(cursor_col, cursor_row, top);
        wdata        = '0;
        case (state)
            IDLE: begin
                if (wr_fire) begin
                    if (wr_char >= CHAR_W'('h20) && wr_char <= CHAR_W'('h7E)) begin
                        we    = 1'b1;
                        wdata = wr_char;
                        if (cursor_col == CW'(COLS-1))
                            do_nl = 1'b1;
                        else
                            col_nxt = cursor_col + CW'(1);
                    end else if (wr_char == CHAR_W'('h0A)) begin
                        do_nl = 1'b1;
                    end else if (wr_char == CHAR_W'('h0D)) begin
                        col_nxt = '0;
                    end else if (wr_char == CHAR_W'('h08)) begin
                        if (cursor_col != '0) begin
                            col_nxt = cursor_col - CW'(1);
                            we      = 1'b1;
                            waddr   = cell_addr(cursor_col - CW'(1), cursor_row, top);
                        end else if (cursor_row != '0) begin
                            col_nxt = CW'(COLS-1);
                            row_nxt = cursor_row - RW'(1);
                            we      = 1'b1;
                            waddr   = cell_addr(CW'(COLS-1), cursor_row - RW'(1), top);
                        end
                    end else if (wr_char == CHAR_W'('h0C)) begin
                        top_nxt     = '0;
                        col_nxt     = '0;
                        row_nxt     = '0;
                        scroll_nxt  = '0;
                        clr_idx_nxt = '0;
                        state_nxt   = CLR_ALL;
                    end
                    if (do_nl) begin
                        col_nxt = '0;
                        if (cursor_row != RW'(ROWS-1)) begin
                            row_nxt = cursor_row + RW'(1);
                        end else begin
                            // Old top physical row becomes the new bottom; wipe it.
                            top_nxt      = (top == RW'(ROWS-1)) ? '0 : top + RW'(1);
                            scroll_nxt   = scroll_cnt + 16'd1;
                            clr_base_nxt = AW'(top) * AW'(COLS);
                            clr_idx_nxt  = '0;
                            state_nxt    = CLR_LINE;
                        end
                    end
                end
            end
            CLR_LINE: begin
                we          = 1'b1;
                waddr       = clr_base + clr_idx;
                clr_idx_nxt = clr_idx + AW'(1);
                if (clr_idx == AW'(COLS-1))
                    state_nxt = IDLE;
            end
            CLR_ALL: begin
                we          = 1'b1;
                waddr       = clr_idx;
                clr_idx_nxt = clr_idx + AW'(1);
                if (clr_idx == AW'(COLS*ROWS-1))
                    state_nxt = IDLE;
            end
            default: state_nxt = CLR_ALL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLR_ALL;
            clr_idx    <= '0;
            clr_base   <= '0;
            top        <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            scroll_cnt <= '0;
        end else begin
            state      <= state_nxt;
            clr_idx    <= clr_idx_nxt;
            clr_base   <= clr_base_nxt;
            top        <= top_nxt;
            cursor_col <= col_nxt;
            cursor_row <= row_nxt;
            scroll_cnt <= scroll_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !rst)
            mem[waddr] <= wdata;
    end

    // Read port: old data on a same-cycle write to the same cell.
    assign rd_in_range = ({1'b0, rd_col} < (CW+1)'(COLS)) && ({1'b0, rd_row} < (RW+1)'(ROWS));
    assign raddr       = rd_in_range ? cell_addr(rd_col, rd_row, top) : '0;

    always_ff @(posedge clk) begin
        if (rst || state == CLR_ALL || !rd_in_range)
            rd_char <= '0;
        else
            rd_char <= mem[raddr];
    end
endmodule
